mem_wb_writeback: RTL and testbench
===================================

Name: mem_wb_writeback

Overview:
- MEM/WB pipeline register plus writeback logic for the RV32I core.
- Sits directly upstream of the register file. Drives its write port (reg_write, write_reg, write_data).
- Captures the MEM-stage result each cycle and selects the final write value: ALU result, sign/zero-extended load data, or PC+4.
- Suppresses illegal writes and provides a retire counter plus a hazard-unit forwarding view.

Parameters:
- XLEN, 32, datapath width.
- REG_ADDR_W, 5, register index width.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  MEM stage holds a real instruction
- in_reg_write  input  1  instruction writes rd
- in_rd  input  REG_ADDR_W  destination register
- in_wb_sel  input  2  00=ALU, 01=LOAD, 10=PC+4, 11=reserved
- in_funct3  input  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
- in_alu_result  input  XLEN  ALU result; this is also the load address
- in_load_data  input  XLEN  raw word-aligned word from data memory
- in_pc_plus4  input  XLEN  link value
- stall  input  1  hold the WB stage contents
- flush  input  1  replace the WB stage contents with a bubble
- reg_write  output  1  register-file write enable
- write_reg  output  REG_ADDR_W  register-file write address
- write_data  output  XLEN  register-file write data
- fwd_valid  output  1  WB result is forwardable (equals reg_write)
- misaligned  output  1  the current WB instruction is a misaligned load
- retire_count  output  32  instructions retired

Behaviour:
- Register update priority at each posedge clk: reset > flush > stall > capture.
  - reset: clear valid_q, rw_q, rd_q, sel_q, f3_q, alu_q, ld_q, pc4_q and retire_count to 0.
  - flush: valid_q <= 0. Other fields are don't-care; they are cleared to 0. retire_count still updates by the rule below, using the pre-flush valid_q.
  - stall: all stage registers hold. The register file sees the same write repeated, which is idempotent and allowed.
  - capture: every in_* field is loaded into its *_q register.
- Latency: one cycle from the MEM inputs to the register-file write outputs. All outputs are combinational from the *_q registers only, with no input-to-output path.
- Load extension uses off = alu_q[1:0]:
  - LB/LBU: select byte off, then sign- or zero-extend.
  - LH/LHU: select halfword off[1], then extend.
  - LW: full word.
  - Undefined funct3 values (011, 110, 111) on a load produce data 0 and count as misaligned.
- Misalignment:
  - LH/LHU is misaligned when off[0]=1.
  - LW is misaligned when off != 0.
  - misaligned = valid_q & (sel_q==01) & cond.
- write_data:
  - sel 00: alu_q
  - sel 01: extended load value
  - sel 10: pc4_q
  - sel 11: 0
- reg_write = valid_q & rw_q & (rd_q != 0) & (sel_q != 11) & ~misaligned. Writes to x0 are never issued.
- write_reg = rd_q whenever valid_q=1; otherwise 0.
- retire_count increments by 1 on each posedge where valid_q=1 and stall=0, including misaligned loads and flush cycles. It wraps 0xFFFFFFFF -> 0.
- Reset values of outputs: reg_write 0, write_reg 0, write_data 0, fwd_valid 0, misaligned 0, retire_count 0.
- A reset asserted mid-stall or mid-flush clears the stage unconditionally on that edge.

Decomposition:
- The shared package riscv_pkg holds:
  - WB_SEL_ALU/LOAD/PC4/RSV codes
  - F3_LB/LH/LW/LBU/LHU constants
  - XLEN and REG_ADDR_W defaults
- One combinational sub-module, load_extend (inputs: word, offset, funct3; outputs: data, misaligned). It is reused later by the forwarding path.

Test Plan:
- ALU write: in_valid=1, rw=1, rd=5, sel=00, alu=0x1234_5678 -> next cycle reg_write=1, write_reg=5, write_data=0x12345678, retire_count=1 on the following edge.
- Load extension: ld=0x80FF_7F01.
  - LB off=2 -> 0xFFFFFFFF
  - LBU off=3 -> 0x00000080
  - LH off=0 -> 0x00007F01
  - LHU off=2 -> 0x000080FF
- x0 and misalignment:
  - rd=0 with sel=00 -> reg_write=0 while retire_count still increments.
  - LW with alu=0x1002 -> misaligned=1, reg_write=0.
- Stall/flush:
  - Capture rd=7, then assert stall for 3 cycles with changing inputs -> outputs hold rd=7 data and retire_count is unchanged.
  - stall+flush together -> next cycle reg_write=0.
- JAL link: sel=10, pc4=0x0000_0104, rd=1 -> write_data=0x00000104.
- Reset:
  - Assert reset mid-stream -> all outputs 0 on the next edge.
  - Preload retire_count near 0xFFFFFFFF via long run or forced state -> wraps to 0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: writeback select codes,
// load funct3 encodings and datapath widths.
package riscv_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    WB_SEL_ALU  = 2'b00,
    WB_SEL_LOAD = 2'b01,
    WB_SEL_PC4  = 2'b10,
    WB_SEL_RSV  = 2'b11
  } wb_sel_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/mem_wb_writeback_load_extend.sv
// Load byte/halfword lane select and sign/zero extension,
// with alignment check for the addressed access size.
module load_extend
  import riscv_pkg::*;
#(
  parameter int W = XLEN
) (
  input  logic [W-1:0] word,
  input  logic [1:0]   offset,
  input  logic [2:0]   funct3,
  output logic [W-1:0] data,
  output logic         misaligned
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = word[7:0];
    unique case (offset)
      2'd0: byte_v = word[7:0];
      2'd1: byte_v = word[15:8];
      2'd2: byte_v = word[23:16];
      2'd3: byte_v = word[31:24];
      default: byte_v = word[7:0];
    endcase
    half_v = offset[1] ? word[31:16] : word[15:0];
  end

  always_comb begin
    data       = '0;
    misaligned = 1'b0;
    unique case (1'b1)
      funct3 == F3_LB: begin
        data = {{(W-8){byte_v[7]}}, byte_v};
      end
      funct3 == F3_LBU: begin
        data = {{(W-8){1'b0}}, byte_v};
      end
      funct3 == F3_LH: begin
        data       = {{(W-16){half_v[15]}}, half_v};
        misaligned = offset[0];
      end
      funct3 == F3_LHU: begin
        data       = {{(W-16){1'b0}}, half_v};
        misaligned = offset[0];
      end
      funct3 == F3_LW: begin
        data       = word;
        misaligned = |offset;
      end
      default: begin
        // undefined load width: no data, treated as a bad access
        data       = '0;
        misaligned = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/mem_wb_writeback.sv
// MEM/WB pipeline register and writeback mux feeding the
// register-file write port, plus retire counter.
module mem_wb_writeback
  import riscv_pkg::*;
#(
  parameter int XLEN       = riscv_pkg::XLEN,
  parameter int REG_ADDR_W = riscv_pkg::REG_ADDR_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic                  in_reg_write,
  input  logic [REG_ADDR_W-1:0] in_rd,
  input  logic [1:0]            in_wb_sel,
  input  logic [2:0]            in_funct3,
  input  logic [XLEN-1:0]       in_alu_result,
  input  logic [XLEN-1:0]       in_load_data,
  input  logic [XLEN-1:0]       in_pc_plus4,
  input  logic                  stall,
  input  logic                  flush,
  output logic                  reg_write,
  output logic [REG_ADDR_W-1:0] write_reg,
  output logic [XLEN-1:0]       write_data,
  output logic                  fwd_valid,
  output logic                  misaligned,
  output logic [31:0]           retire_count
);

  logic                  valid_q;
  logic                  rw_q;
  logic [REG_ADDR_W-1:0] rd_q;
  wb_sel_e               sel_q;
  logic [2:0]            f3_q;
  logic [XLEN-1:0]       alu_q;
  logic [XLEN-1:0]       ld_q;
  logic [XLEN-1:0]       pc4_q;
  logic [31:0]           retire_q;

  logic [XLEN-1:0]       ext_data;
  logic                  ext_bad;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      valid_q <= 1'b0;
      rw_q    <= 1'b0;
      rd_q    <= '0;
      sel_q   <= WB_SEL_ALU;
      f3_q    <= '0;
      alu_q   <= '0;
      ld_q    <= '0;
      pc4_q   <= '0;
    end else if (!stall) begin
      valid_q <= in_valid;
      rw_q    <= in_reg_write;
      rd_q    <= in_rd;
      sel_q   <= wb_sel_e'(in_wb_sel);
      f3_q    <= in_funct3;
      alu_q   <= in_alu_result;
      ld_q    <= in_load_data;
      pc4_q   <= in_pc_plus4;
    end
  end

  // the instruction leaving WB retires even when the edge flushes
  always_ff @(posedge clk) begin
    if (reset) begin
      retire_q <= '0;
    end else if (valid_q && !stall) begin
      retire_q <= retire_q + 32'd1;
    end
  end

  load_extend #(
    .W(XLEN)
  ) u_load_extend (
    .word       (ld_q),
    .offset     (alu_q[1:0]),
    .funct3     (f3_q),
    .data       (ext_data),
    .misaligned (ext_bad)
  );

  always_comb begin
    misaligned = valid_q & (sel_q == WB_SEL_LOAD) & ext_bad;
    write_data = '0;
    unique case (sel_q)
      WB_SEL_ALU:  write_data = alu_q;
      WB_SEL_LOAD: write_data = ext_data;
      WB_SEL_PC4:  write_data = pc4_q;
      WB_SEL_RSV:  write_data = '0;
      default:     write_data = '0;
    endcase
  end

  always_comb begin
    reg_write = valid_q & rw_q & (|rd_q)
              & (sel_q != WB_SEL_RSV) & ~misaligned;
    write_reg = valid_q ? rd_q : '0;
    fwd_valid = reg_write;
  end

  assign retire_count = retire_q;

endmodule

// File: tb/tb_mem_wb_writeback.sv
// Scoreboard bench for mem_wb_writeback: expected writes queued
// at drive time and compared one cycle later.
module tb_mem_wb_writeback;

  typedef struct {
    logic        rw;
    logic [4:0]  wr;
    logic [31:0] wd;
    logic        mis;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_reg_write = 1'b0;
  logic [4:0]  in_rd = '0;
  logic [1:0]  in_wb_sel = '0;
  logic [2:0]  in_funct3 = '0;
  logic [31:0] in_alu_result = '0;
  logic [31:0] in_load_data = '0;
  logic [31:0] in_pc_plus4 = '0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        reg_write;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic        fwd_valid;
  logic        misaligned;
  logic [31:0] retire_count;

  exp_t        sb[$];
  exp_t        last_exp;
  logic        m_valid = 1'b0;
  logic [31:0] m_rc = '0;
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  mem_wb_writeback dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_reg_write (in_reg_write),
    .in_rd        (in_rd),
    .in_wb_sel    (in_wb_sel),
    .in_funct3    (in_funct3),
    .in_alu_result(in_alu_result),
    .in_load_data (in_load_data),
    .in_pc_plus4  (in_pc_plus4),
    .stall        (stall),
    .flush        (flush),
    .reg_write    (reg_write),
    .write_reg    (write_reg),
    .write_data   (write_data),
    .fwd_valid    (fwd_valid),
    .misaligned   (misaligned),
    .retire_count (retire_count)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(
    input logic v, input logic rw,
    input logic [4:0] rd, input logic [1:0] sel,
    input logic [2:0] f3, input logic [31:0] alu,
    input logic [31:0] ld, input logic [31:0] pc4);
    exp_t m;
    logic [31:0] b, h, ext;
    logic bad;
    b = ld >> (8 * alu[1:0]);
    h = ld >> (16 * alu[1]);
    ext = '0;
    bad = 1'b0;
    case (f3)
      3'b000: ext = {{24{b[7]}}, b[7:0]};
      3'b100: ext = {24'h0, b[7:0]};
      3'b001: begin ext = {{16{h[15]}}, h[15:0]}; bad = alu[0]; end
      3'b101: begin ext = {16'h0, h[15:0]}; bad = alu[0]; end
      3'b010: begin ext = ld; bad = (alu[1:0] != 2'b00); end
      default: begin ext = '0; bad = 1'b1; end
    endcase
    m.mis = v && (sel == 2'b01) && bad;
    case (sel)
      2'b00:   m.wd = alu;
      2'b01:   m.wd = ext;
      2'b10:   m.wd = pc4;
      default: m.wd = '0;
    endcase
    m.rw = v && rw && (rd != 0) && (sel != 2'b11) && !m.mis;
    m.wr = v ? rd : 5'd0;
    return m;
  endfunction

  task automatic step(
    input logic rst, input logic v, input logic rw,
    input logic [4:0] rd, input logic [1:0] sel,
    input logic [2:0] f3, input logic [31:0] alu,
    input logic [31:0] ld, input logic [31:0] pc4,
    input logic stl, input logic fl);
    exp_t e;
    exp_t bub;
    @(negedge clk);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("reg_write", {31'b0, reg_write}, {31'b0, e.rw});
      chk("fwd_valid", {31'b0, fwd_valid}, {31'b0, e.rw});
      chk("write_reg", {27'b0, write_reg}, {27'b0, e.wr});
      chk("write_data", write_data, e.wd);
      chk("misaligned", {31'b0, misaligned}, {31'b0, e.mis});
      chk("retire_count", retire_count, m_rc);
    end
    reset = rst; in_valid = v; in_reg_write = rw;
    in_rd = rd; in_wb_sel = sel; in_funct3 = f3;
    in_alu_result = alu; in_load_data = ld;
    in_pc_plus4 = pc4; stall = stl; flush = fl;
    bub = '{rw: 1'b0, wr: 5'd0, wd: 32'd0, mis: 1'b0};
    if (rst) begin
      e = bub; m_rc = '0; m_valid = 1'b0;
    end else begin
      if (m_valid && !stl) m_rc = m_rc + 32'd1;
      if (fl) begin
        e = bub; m_valid = 1'b0;
      end else if (stl) begin
        e = last_exp;
      end else begin
        e = model(v, rw, rd, sel, f3, alu, ld, pc4);
        m_valid = v;
      end
    end
    last_exp = e;
    sb.push_back(e);
  endtask

  task automatic ins(input logic [4:0] rd, input logic [1:0] sel,
                     input logic [2:0] f3, input logic [31:0] alu,
                     input logic [31:0] ld, input logic [31:0] pc4);
    step(1'b0, 1'b1, 1'b1, rd, sel, f3, alu, ld, pc4, 1'b0, 1'b0);
  endtask

  localparam logic [31:0] LDW = 32'h80FF_7F01;

  initial begin
    step(1'b1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1'b1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    ins(5'd5, 2'b00, 3'b000, 32'h1234_5678, 0, 0);
    ins(5'd6, 2'b01, 3'b000, 32'h0000_0002, LDW, 0);
    ins(5'd7, 2'b01, 3'b100, 32'h0000_0003, LDW, 0);
    ins(5'd8, 2'b01, 3'b001, 32'h0000_0000, LDW, 0);
    ins(5'd9, 2'b01, 3'b101, 32'h0000_0002, LDW, 0);
    ins(5'd0, 2'b00, 3'b000, 32'hDEAD_BEEF, 0, 0);
    ins(5'd10, 2'b01, 3'b010, 32'h0000_1002, LDW, 0);
    ins(5'd11, 2'b01, 3'b001, 32'h0000_0003, LDW, 0);
    ins(5'd12, 2'b01, 3'b011, 32'h0000_0000, LDW, 0);
    ins(5'd13, 2'b11, 3'b000, 32'h5555_5555, 0, 0);
    ins(5'd7, 2'b00, 3'b000, 32'h0000_AAAA, 0, 0);
    for (int i = 0; i < 3; i++)
      step(0, 1, 1, 5'(20 + i), 2'b00, 0, 32'(i * 77 + 3),
           0, 0, 1'b1, 1'b0);
    step(0, 1, 1, 5'd14, 2'b00, 0, 32'h7777, 0, 0, 1'b1, 1'b1);
    ins(5'd1, 2'b10, 3'b000, 32'h0, 0, 32'h0000_0104);
    step(0, 0, 1, 5'd3, 2'b00, 0, 32'h99, 0, 0, 0, 0);
    ins(5'd2, 2'b00, 3'b000, 32'h1, 0, 0);
    ins(5'd3, 2'b00, 3'b000, 32'h2, 0, 0);
    // preload the retire counter just below wrap
    force dut.retire_q = 32'hFFFF_FFFE;
    #1 release dut.retire_q;
    m_rc = 32'hFFFF_FFFF;
    ins(5'd4, 2'b00, 3'b000, 32'h3, 0, 0);
    ins(5'd5, 2'b00, 3'b000, 32'h4, 0, 0);
    for (int i = 0; i < 40; i++)
      step(0, 1'($urandom), 1'($urandom), 5'($urandom),
           2'($urandom), 3'($urandom), $urandom, $urandom,
           $urandom, 1'($urandom_range(0, 3) == 0),
           1'($urandom_range(0, 5) == 0));
    ins(5'd9, 2'b00, 3'b000, 32'hCAFE, 0, 0);
    step(1'b1, 1, 1, 5'd9, 2'b00, 0, 32'h1, 0, 0, 1'b1, 1'b1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
